// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period in prescaler ticks and recovers the
// duty code with a serial restoring divider; flags a stuck input line as a timeout.
module pwm_capture #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 15,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [TIMER_BITS-1:0] FINAL_VALUE,
  input  logic                  pwm_in,
  output logic [CNT_BITS-1:0]   high_count,
  output logic [CNT_BITS-1:0]   period_count,
  output logic [R:0]            duty,
  output logic                  valid,
  output logic                  timeout,
  output logic                  stuck_level,
  output logic                  overrun
);
  localparam int ITW = $clog2(R + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
  localparam logic [R:0]          DUTY_FULL = {1'b1, {R{1'b0}}};
  localparam logic [ITW-1:0]      LAST_ITER = ITW'(R);

  typedef enum logic {WAIT_RISE, MEASURE} meas_state_t;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

  logic                  r_sync1, r_sync2, r_prev;
  logic                  w_rise;
  logic [TIMER_BITS-1:0] r_presc;
  logic                  w_tick;

  meas_state_t           r_state, w_stateNext;
  logic [CNT_BITS-1:0]   r_hiCnt, r_perCnt, w_hiNext, w_perNext;
  logic [CNT_BITS-1:0]   w_hiInc, w_perInc, w_hiCap, w_perCap;
  logic                  w_capture, w_timeoutEvt;

  div_state_t            r_divState, w_divNext;
  logic                  w_divBusy, w_divStart, w_overrunNext;
  logic [CNT_BITS:0]     r_rem, w_remTrial, w_divisorExt;
  logic [CNT_BITS-1:0]   r_divisor, r_capHi;
  logic [R:0]            r_quot, w_quotClamped;
  logic [ITW-1:0]        r_iter;
  logic                  w_qbit;

  logic                  r_toPend, r_toLevel;

  // Two flops resynchronise the pin; the third holds the previous level so
  // both edges see the same delay and measured widths stay exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;
  assign w_tick = enable && (r_presc >= FINAL_VALUE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_presc <= '0;
    else if (!enable || w_tick)  r_presc <= '0;
    else                         r_presc <= r_presc + TIMER_BITS'(1);
  end

  // Captured values include the tick of the closing rise cycle; the new
  // period starts from zero so that tick is never counted twice.
  assign w_perInc = (r_perCnt == CNT_MAX) ? CNT_MAX : r_perCnt + CNT_BITS'(1);
  assign w_hiInc  = (r_hiCnt == CNT_MAX) ? CNT_MAX : r_hiCnt + CNT_BITS'(1);
  assign w_perCap = w_tick ? w_perInc : r_perCnt;
  assign w_hiCap  = (w_tick && r_sync2) ? w_hiInc : r_hiCnt;

  always_comb begin
    w_stateNext  = r_state;
    w_hiNext     = r_hiCnt;
    w_perNext    = r_perCnt;
    w_capture    = 1'b0;
    w_timeoutEvt = 1'b0;
    if (!enable) begin
      w_stateNext = WAIT_RISE;
      w_hiNext    = '0;
      w_perNext   = '0;
    end else begin
      case (r_state)
        WAIT_RISE: begin
          w_hiNext  = '0;
          w_perNext = '0;
          if (w_rise) w_stateNext = MEASURE;
        end
        MEASURE: begin
          if (w_rise) begin
            w_hiNext  = '0;
            w_perNext = '0;
            w_capture = (w_perCap != '0);
          end else if (w_tick) begin
            if (w_perInc == CNT_MAX) begin
              w_timeoutEvt = 1'b1;
              w_stateNext  = WAIT_RISE;
              w_hiNext     = '0;
              w_perNext    = '0;
            end else begin
              w_hiNext  = w_hiCap;
              w_perNext = w_perInc;
            end
          end
        end
        default: w_stateNext = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= WAIT_RISE;
      r_hiCnt  <= '0;
      r_perCnt <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_hiCnt  <= w_hiNext;
      r_perCnt <= w_perNext;
    end
  end

  assign w_divBusy     = (r_divState != DIV_IDLE);
  assign w_divStart    = w_capture && !w_divBusy;
  assign w_overrunNext = w_capture && w_divBusy;

  always_comb begin
    w_divNext = r_divState;
    case (r_divState)
      DIV_IDLE: if (w_divStart) w_divNext = DIV_RUN;
      DIV_RUN:  if (r_iter == LAST_ITER) w_divNext = DIV_DONE;
      DIV_DONE: w_divNext = DIV_IDLE;
      default:  w_divNext = DIV_IDLE;
    endcase
  end

  // Remainder starts at hi, which stands for hi<<R; each step yields the
  // next quotient bit from weight 2^R downwards.
  assign w_divisorExt = {1'b0, r_divisor};
  assign w_qbit       = (r_rem >= w_divisorExt);
  assign w_remTrial   = r_rem - w_divisorExt;
  assign w_quotClamped = (r_quot > DUTY_FULL) ? DUTY_FULL : r_quot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_divState <= DIV_IDLE;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_capHi    <= '0;
      r_quot     <= '0;
      r_iter     <= '0;
    end else begin
      r_divState <= w_divNext;
      if (w_divStart) begin
        r_rem     <= {1'b0, w_hiCap};
        r_divisor <= w_perCap;
        r_capHi   <= w_hiCap;
        r_quot    <= '0;
        r_iter    <= '0;
      end else if (r_divState == DIV_RUN) begin
        r_rem  <= (w_qbit ? w_remTrial : r_rem) << 1;
        r_quot <= {r_quot[R-1:0], w_qbit};
        r_iter <= r_iter + ITW'(1);
      end
    end
  end

  // A timeout is held back until the divider is idle so it never collides
  // with the valid of a divide already in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_toPend  <= 1'b0;
      r_toLevel <= 1'b0;
    end else if (w_timeoutEvt) begin
      r_toPend  <= 1'b1;
      r_toLevel <= r_sync2;
    end else if (r_toPend && !w_divBusy) begin
      r_toPend  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_count   <= '0;
      period_count <= '0;
      duty         <= '0;
      valid        <= 1'b0;
      timeout      <= 1'b0;
      stuck_level  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= w_overrunNext;
      if (r_divState == DIV_DONE) begin
        high_count   <= r_capHi;
        period_count <= r_divisor;
        duty         <= w_quotClamped;
        valid        <= 1'b1;
        timeout      <= 1'b0;
      end else if (r_toPend && !w_divBusy) begin
        high_count   <= r_toLevel ? CNT_MAX : '0;
        period_count <= CNT_MAX;
        duty         <= r_toLevel ? DUTY_FULL : '0;
        valid        <= 1'b1;
        timeout      <= 1'b1;
        stuck_level  <= r_toLevel;
      end
    end
  end

endmodule
